// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS instruction encoder with address-tagged output FIFO
// Encodes symbolic requests into 32-bit words and queues them with their byte address.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [10:0] word_cnt,
  output logic        limit_hit,
  output logic        err,
  output logic [3:0]  err_op
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   addr_mem_q  [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [10:0]   word_cnt_q, word_cnt_d;
  logic          err_q, err_d;
  logic [3:0]    err_op_q, err_op_d;

  logic [31:0] enc_word;
  logic [31:0] tag;
  logic        full, legal, accept, push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign limit_hit = (word_cnt_q == 11'(MAX_WORDS));
  assign req_ready = !full && !limit_hit && !clear;
  assign accept    = req_valid && req_ready;
  assign legal     = (op_sel <= 4'd10);
  assign push      = accept && legal;
  assign out_valid = (count_q != '0);
  // clear wins over a pop in the same cycle
  assign pop       = out_valid && out_ready && !clear;
  assign tag       = BASE_ADDR + {19'd0, word_cnt_q, 2'b00};

  assign out_instr = instr_mem_q[rd_ptr_q];
  assign out_addr  = addr_mem_q[rd_ptr_q];
  assign word_cnt  = word_cnt_q;
  assign err       = err_q;
  assign err_op    = err_op_q;

  always_comb begin
    enc_word = 32'h0000_0000;
    case (op_sel)
      4'd1:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
      4'd2:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
      4'd3:    enc_word = {6'b001101, rs, rt, imm16};
      4'd4:    enc_word = {6'b001111, 5'b00000, rt, imm16};
      4'd5:    enc_word = {6'b100011, rs, rt, imm16};
      4'd6:    enc_word = {6'b101011, rs, rt, imm16};
      4'd7:    enc_word = {6'b000100, rs, rt, imm16};
      4'd8:    enc_word = {6'b000010, target26};
      4'd9:    enc_word = {6'b000011, target26};
      4'd10:   enc_word = {6'b000000, rs, 15'd0, 6'b001000};
      default: enc_word = 32'h0000_0000;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    err_op_d   = err_op_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      word_cnt_d = '0;
      err_d      = 1'b0;
      err_op_d   = 4'd0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        word_cnt_d = word_cnt_q + 11'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      // illegal requests complete the handshake but only raise the sticky error
      if (accept && !legal) begin
        err_d = 1'b1;
        if (!err_q) err_op_d = op_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      err_op_q   <= 4'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      err_op_q   <= err_op_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= 32'h0000_0000;
        addr_mem_q[i]  <= BASE_ADDR;
      end
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= 32'h0000_0000;
        addr_mem_q[i]  <= BASE_ADDR;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= enc_word;
      addr_mem_q[wr_ptr_q]  <= tag;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
// Directed test-plan scenarios plus randomized traffic against a queue-based reference model.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr, out_addr;
  logic [10:0] word_cnt;
  logic        limit_hit, err;
  logic [3:0]  err_op;

  logic        l_req_ready, l_out_valid, l_limit_hit, l_err;
  logic [31:0] l_out_instr, l_out_addr;
  logic [10:0] l_word_cnt;
  logic [3:0]  l_err_op;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          m_cnt, m_occ, m_errop;
  logic        m_err;
  logic        acc_seen;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_3000), .MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .target26(target26),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .word_cnt(word_cnt), .limit_hit(limit_hit), .err(err), .err_op(err_op)
  );

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_3000), .MAX_WORDS(3)) dut_lim (
    .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(l_req_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .target26(target26),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_instr(l_out_instr), .out_addr(l_out_addr),
    .word_cnt(l_word_cnt), .limit_hit(l_limit_hit), .err(l_err), .err_op(l_err_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field-level MIPS encoding built from opcode/funct numbers with shifts.
  function automatic logic [31:0] ref_enc(int unsigned op, int unsigned s, int unsigned t,
                                          int unsigned d, int unsigned im, int unsigned tg);
    int unsigned w;
    case (op)
      1:       w = (s << 21) | (t << 16) | (d << 11) | 33;
      2:       w = (s << 21) | (t << 16) | (d << 11) | 35;
      3:       w = (13 << 26) | (s << 21) | (t << 16) | im;
      4:       w = (15 << 26) | (t << 16) | im;
      5:       w = (35 << 26) | (s << 21) | (t << 16) | im;
      6:       w = (43 << 26) | (s << 21) | (t << 16) | im;
      7:       w = (4 << 26) | (s << 21) | (t << 16) | im;
      8:       w = (2 << 26) | tg;
      9:       w = (3 << 26) | tg;
      10:      w = (s << 21) | 8;
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    obs_q.delete();
    m_cnt = 0; m_occ = 0; m_err = 1'b0; m_errop = 0;
  endtask

  // One cycle: sample handshakes before the edge, update the model, advance to next negedge.
  task automatic tick();
    #1;
    acc_seen = req_valid && req_ready;
    if (clear) begin
      while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
      m_cnt = 0; m_occ = 0; m_err = 1'b0; m_errop = 0;
    end else begin
      if (out_valid && out_ready) begin
        obs_q.push_back({out_instr, out_addr});
        m_occ--;
      end
      if (acc_seen) begin
        if (op_sel <= 4'd10) begin
          exp_q.push_back({ref_enc(op_sel, rs, rt, rd, imm16, target26),
                           32'h0000_3000 + 32'(m_cnt * 4)});
          m_cnt++;
          m_occ++;
        end else begin
          if (!m_err) m_errop = int'(op_sel);
          m_err = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
    int n;
    op_sel = op; rs = s; rt = t; rd = d; imm16 = im; target26 = tg;
    req_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_seen && n < 50);
    checks++;
    if (!acc_seen) begin
      errors++;
      $display("FAIL send_timeout: op=%0d not accepted within %0d cycles", op, n);
    end
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid) begin
      errors++;
      $display("FAIL drain_timeout: out_valid still 1 after %0d cycles", n);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0; clear = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
    op_sel = 4'd0; rs = '0; rt = '0; rd = '0; imm16 = '0; target26 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 32'h3000 ||
        word_cnt !== 11'd0 || limit_hit !== 1'b0 || err !== 1'b0 || err_op !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b instr=%h addr=%h cnt=%0d lim=%b err=%b op=%0d, required 0 0 3000 0 0 0 0",
               out_valid, out_instr, out_addr, word_cnt, limit_hit, err, err_op);
    end
    apply_reset();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_ori();
    apply_reset();
    send(4'd3, 5'd0, 5'd1, 5'd7, 16'h1234, 26'h3ff_ffff);
    req_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h3401_1234 || out_addr !== 32'h3000 || word_cnt !== 11'd1) begin
      errors++;
      $display("FAIL ori_latency: valid=%b instr=%h addr=%h cnt=%0d, required 1 34011234 00003000 1",
               out_valid, out_instr, out_addr, word_cnt);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ei [5];
    ei = '{32'h0022_1821, 32'h0022_1823, 32'h3C01_FFFF, 32'h8C22_0004, 32'hAC22_0008};
    apply_reset();
    out_ready = 1'b1;
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h155_5555);
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h155_5555);
    send(4'd4, 5'd5, 5'd1, 5'd9, 16'hFFFF, 26'h155_5555);
    send(4'd5, 5'd1, 5'd2, 5'd9, 16'h0004, 26'h155_5555);
    send(4'd6, 5'd1, 5'd2, 5'd9, 16'h0008, 26'h155_5555);
    drain();
    checks++;
    if (obs_q.size() != 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d words, required 5", obs_q.size());
    end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== {ei[i], 32'h3000 + 32'(4 * i)}) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h, required %h@%h", i, obs_q[i], ei[i], 32'h3000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_control_flow();
    logic [31:0] ei [4];
    ei = '{32'h1022_FFFF, 32'h0800_0C00, 32'h0C00_0C03, 32'h03E0_0008};
    apply_reset();
    out_ready = 1'b1;
    send(4'd7, 5'd1, 5'd2, 5'd4, 16'hFFFF, 26'h3ff_ffff);
    send(4'd8, 5'd3, 5'd3, 5'd3, 16'hFFFF, 26'h000_0C00);
    send(4'd9, 5'd3, 5'd3, 5'd3, 16'hFFFF, 26'h000_0C03);
    send(4'd10, 5'd31, 5'h1F, 5'h1F, 16'hFFFF, 26'h3ff_ffff);
    drain();
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL ctrl_count: got %0d words, required 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i][63:32] !== ei[i]) begin
        errors++;
        $display("FAIL ctrl_word%0d: got %h, required %h", i, obs_q[i][63:32], ei[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd3, 5'd0, 5'd1, 5'd0, 16'(i), 26'd0);
    op_sel = 4'd3; rs = 5'd0; rt = 5'd1; imm16 = 16'd4;
    req_valid = 1'b1;
    held = {out_instr, out_addr};
    repeat (3) begin
      tick();
      checks++;
      if (req_ready !== 1'b0 || acc_seen !== 1'b0 || {out_instr, out_addr} !== held) begin
        errors++;
        $display("FAIL bp_hold: ready=%b acc=%b head=%h, required 0 0 %h", req_ready, acc_seen,
                 {out_instr, out_addr}, held);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (acc_seen !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_bypass: accepted=%b while full and popping, required 0", acc_seen);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after_pop: req_ready=%b required 1", req_ready);
    end
    tick();
    checks++;
    if (acc_seen !== 1'b1) begin
      errors++;
      $display("FAIL bp_fifth_accept: accepted=%b required 1", acc_seen);
    end
    drain();
    checks++;
    if (obs_q.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d words, required 5", obs_q.size());
    end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== {32'h3401_0000 + 32'(i), 32'h3000 + 32'(4 * i)}) begin
        errors++;
        $display("FAIL bp_word%0d: got %h, required %h@%h", i, obs_q[i], 32'h3401_0000 + 32'(i),
                 32'h3000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    out_ready = 1'b0;
    send(4'd12, 5'd1, 5'd2, 5'd3, 16'h1111, 26'd5);
    send(4'd14, 5'd1, 5'd2, 5'd3, 16'h1111, 26'd5);
    send(4'd0, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3ff_ffff);
    req_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || err_op !== 4'd12 || word_cnt !== 11'd1) begin
      errors++;
      $display("FAIL illegal_flags: err=%b err_op=%0d cnt=%0d, required 1 12 1", err, err_op, word_cnt);
    end
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {32'h0, 32'h3000}) begin
      errors++;
      $display("FAIL illegal_output: %0d words, first=%h, required 1 word 00000000@00003000",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0);
    end
  endtask

  task automatic test_limit_clear();
    logic rdy [4];
    logic hit [4];
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_sel = 4'd3; rs = 5'd0; rt = 5'd1; imm16 = 16'(i);
      req_valid = 1'b1;
      #1;
      rdy[i] = l_req_ready;
      hit[i] = l_limit_hit;
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdy[i] !== (i < 3) || hit[i] !== (i == 3)) begin
        errors++;
        $display("FAIL limit_req%0d: ready=%b limit_hit=%b, required %b %b", i, rdy[i], hit[i], i < 3, i == 3);
      end
    end
    checks++;
    if (l_limit_hit !== 1'b1 || l_word_cnt !== 11'd3) begin
      errors++;
      $display("FAIL limit_state: limit_hit=%b cnt=%0d, required 1 3", l_limit_hit, l_word_cnt);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    checks++;
    if (l_word_cnt !== 11'd0 || l_limit_hit !== 1'b0 || l_out_valid !== 1'b0 || l_req_ready !== 1'b1 ||
        out_valid !== 1'b0 || word_cnt !== 11'd0 || out_addr !== 32'h3000) begin
      errors++;
      $display("FAIL clear_state: cnt=%0d lim=%b valid=%b ready=%b main_valid=%b main_cnt=%0d addr=%h",
               l_word_cnt, l_limit_hit, l_out_valid, l_req_ready, out_valid, word_cnt, out_addr);
    end
    out_ready = 1'b0;
    send(4'd3, 5'd0, 5'd1, 5'd0, 16'h0042, 26'd0);
    req_valid = 1'b0;
    checks++;
    if (l_out_valid !== 1'b1 || l_out_addr !== 32'h3000 || l_out_instr !== 32'h3401_0042) begin
      errors++;
      $display("FAIL clear_next_word: valid=%b instr=%h addr=%h, required 1 34010042 00003000",
               l_out_valid, l_out_instr, l_out_addr);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b0;
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || l_out_valid !== 1'b0 || word_cnt !== 11'd0 || out_addr !== 32'h3000) begin
      errors++;
      $display("FAIL reset_async: valid=%b l_valid=%b cnt=%0d addr=%h, required 0 0 0 00003000",
               out_valid, l_out_valid, word_cnt, out_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_random();
    logic exp_rdy;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = ($urandom % 4) != 0;
      op_sel    = (($urandom % 8) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      rs        = 5'($urandom);
      rt        = 5'($urandom);
      rd        = 5'($urandom);
      imm16     = 16'($urandom);
      target26  = 26'($urandom);
      out_ready = ($urandom % 3) != 0;
      clear     = ($urandom % 50) == 0;
      #1;
      exp_rdy = !clear && (m_occ < 4) && (m_cnt < 1024);
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready cyc%0d: req_ready=%b required %b", cyc, req_ready, exp_rdy);
      end
      tick();
    end
    clear = 1'b0;
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_word%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (word_cnt !== 11'(m_cnt) || err !== m_err || (m_err && err_op !== 4'(m_errop))) begin
      errors++;
      $display("FAIL rand_status: cnt=%0d err=%b err_op=%0d, required %0d %b %0d",
               word_cnt, err, err_op, m_cnt, m_err, m_errop);
    end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
    op_sel = 4'd0; rs = '0; rt = '0; rd = '0; imm16 = '0; target26 = '0;
    acc_seen = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_ori();
    test_back_to_back();
    test_control_flow();
    test_backpressure();
    test_illegal();
    test_limit_clear();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
